led_panel_rx: RTL and testbench

//  Panel-side receiver for the scan_fsm serial LED interface: data lines, shift clock, STB latch, OE, row select.

---
 rtl/led_panel_rx_pkg.sv | 8 +
 rtl/led_panel_rx_sync_edge.sv | 32 +++
 rtl/led_panel_rx.sv | 123 ++++++++++++
 tb/tb_led_panel_rx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/led_panel_rx_pkg.sv
// Shared constants for the serial LED panel receiver.
package led_panel_rx_pkg;
  localparam int unsigned LED_NUM_CH      = 4;
  localparam int unsigned LED_COL_W       = 8;
  localparam int unsigned LED_ROW_W       = 5;
  localparam int unsigned LED_CNT_W       = 16;
  localparam int unsigned LED_SYNC_STAGES = 2;
endpackage

// File: rtl/led_panel_rx_sync_edge.sv
// Multi-flop synchroniser with an extra flop for rising-edge detection.
module led_panel_rx_sync_edge
  import led_panel_rx_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  input  logic [W-1:0] idle,
  output logic [W-1:0] level,
  output logic [W-1:0] rise
);

  logic [LED_SYNC_STAGES-1:0][W-1:0] stg;
  logic [W-1:0]                      prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stg  <= {LED_SYNC_STAGES{idle}};
      prev <= idle;
    end else begin
      stg[0] <= d;
      for (int unsigned i = 1; i < LED_SYNC_STAGES; i++) stg[i] <= stg[i-1];
      prev <= stg[LED_SYNC_STAGES-1];
    end
  end

  assign level = stg[LED_SYNC_STAGES-1];
  assign rise  = level & ~prev;

endmodule

// File: rtl/led_panel_rx.sv
// Panel-side receiver: shifts serial R/G/B chains, latches on STB, gates columns and row drive with OE.
module led_panel_rx
  import led_panel_rx_pkg::*;
#(
  parameter int unsigned NUM_CH = LED_NUM_CH,
  parameter int unsigned COL_W  = LED_COL_W,
  parameter int unsigned ROW_W  = LED_ROW_W,
  parameter int unsigned CNT_W  = LED_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    shift_clk_i,
  input  logic                    latch_i,
  input  logic                    oe_n_i,
  input  logic [NUM_CH-1:0]       led_r_i,
  input  logic [NUM_CH-1:0]       led_g_i,
  input  logic [NUM_CH-1:0]       led_b_i,
  input  logic [ROW_W-1:0]        led_sel_i,
  input  logic                    err_clr_i,
  output logic [NUM_CH*COL_W-1:0] col_r_o,
  output logic [NUM_CH*COL_W-1:0] col_g_o,
  output logic [NUM_CH*COL_W-1:0] col_b_o,
  output logic [2**ROW_W-1:0]     row_o,
  output logic                    latch_pulse_o,
  output logic [CNT_W-1:0]        line_cnt_o,
  output logic                    err_short_o,
  output logic                    err_long_o
);

  localparam int unsigned ROWS = 2**ROW_W;
  localparam int unsigned CW   = $clog2(COL_W + 2);
  localparam int unsigned DW   = 3*NUM_CH + ROW_W;

  // Colour index 0=red, 1=green, 2=blue.
  typedef logic [2:0][NUM_CH-1:0][COL_W-1:0] plane_t;

  logic [2:0] ctl_lvl, ctl_rise;
  logic [DW-1:0] dat_lvl, dat_rise_unused;
  logic shift_rise, latch_rise, oe_n;
  logic [2:0][NUM_CH-1:0] din;
  logic [ROW_W-1:0] sel;

  led_panel_rx_sync_edge #(.W(3)) u_sync_ctl (
    .clk   (clk),
    .rst   (rst),
    .d     ({shift_clk_i, latch_i, oe_n_i}),
    .idle  (3'b001),
    .level (ctl_lvl),
    .rise  (ctl_rise)
  );

  // Data and select share the control path's stage count so data stays aligned with shift edges.
  led_panel_rx_sync_edge #(.W(DW)) u_sync_dat (
    .clk   (clk),
    .rst   (rst),
    .d     ({led_b_i, led_g_i, led_r_i, led_sel_i}),
    .idle  ('0),
    .level (dat_lvl),
    .rise  (dat_rise_unused)
  );

  assign shift_rise  = ctl_rise[2];
  assign latch_rise  = ctl_rise[1];
  assign oe_n        = ctl_lvl[0];
  assign {din, sel}  = dat_lvl;

  plane_t sr, sr_nxt, lat, col;
  logic [CW-1:0] shift_cnt, cnt_nxt;

  // Shift is resolved first so a coincident latch captures the new bit and count.
  always_comb begin
    sr_nxt  = sr;
    cnt_nxt = shift_cnt;
    if (shift_rise) begin
      for (int unsigned k = 0; k < 3; k++)
        for (int unsigned c = 0; c < NUM_CH; c++)
          sr_nxt[k][c] = {sr[k][c][COL_W-2:0], din[k][c]};
      if (shift_cnt != CW'(COL_W + 1)) cnt_nxt = shift_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr            <= '0;
      lat           <= '0;
      col           <= '0;
      shift_cnt     <= '0;
      row_o         <= '0;
      latch_pulse_o <= 1'b0;
      line_cnt_o    <= '0;
      err_short_o   <= 1'b0;
      err_long_o    <= 1'b0;
    end else begin
      sr            <= sr_nxt;
      shift_cnt     <= cnt_nxt;
      latch_pulse_o <= 1'b0;
      if (err_clr_i) begin
        err_short_o <= 1'b0;
        err_long_o  <= 1'b0;
      end
      if (latch_rise) begin
        lat           <= sr_nxt;
        latch_pulse_o <= 1'b1;
        line_cnt_o    <= line_cnt_o + 1'b1;
        shift_cnt     <= '0;
        if (cnt_nxt < CW'(COL_W)) err_short_o <= 1'b1;
        if (cnt_nxt > CW'(COL_W)) err_long_o  <= 1'b1;
      end
      if (oe_n) begin
        col   <= '0;
        row_o <= '0;
      end else begin
        col   <= lat;
        row_o <= ROWS'(1) << sel;
      end
    end
  end

  assign col_r_o = col[0];
  assign col_g_o = col[1];
  assign col_b_o = col[2];

endmodule

// File: tb/tb_led_panel_rx.sv
// Directed bench for led_panel_rx with a narrow-counter instance for the wrap case.
module tb_led_panel_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        shift_clk_i, latch_i, oe_n_i, err_clr_i;
  logic [3:0]  led_r_i, led_g_i, led_b_i;
  logic [4:0]  led_sel_i;
  logic [31:0] col_r_o, col_g_o, col_b_o, row_o;
  logic        latch_pulse_o, err_short_o, err_long_o;
  logic [15:0] line_cnt_o;
  logic [31:0] w_col_r, w_col_g, w_col_b, w_row;
  logic        w_pulse, w_err_s, w_err_l;
  logic [3:0]  w_line;

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned pulses = 0;
  int unsigned p0;

  always #5 clk = ~clk;
  always @(negedge clk) if (latch_pulse_o === 1'b1) pulses++;

  led_panel_rx dut (
    .clk(clk), .rst(rst), .shift_clk_i(shift_clk_i), .latch_i(latch_i), .oe_n_i(oe_n_i),
    .led_r_i(led_r_i), .led_g_i(led_g_i), .led_b_i(led_b_i), .led_sel_i(led_sel_i),
    .err_clr_i(err_clr_i), .col_r_o(col_r_o), .col_g_o(col_g_o), .col_b_o(col_b_o),
    .row_o(row_o), .latch_pulse_o(latch_pulse_o), .line_cnt_o(line_cnt_o),
    .err_short_o(err_short_o), .err_long_o(err_long_o)
  );

  led_panel_rx #(.CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .shift_clk_i(shift_clk_i), .latch_i(latch_i), .oe_n_i(oe_n_i),
    .led_r_i(led_r_i), .led_g_i(led_g_i), .led_b_i(led_b_i), .led_sel_i(led_sel_i),
    .err_clr_i(err_clr_i), .col_r_o(w_col_r), .col_g_o(w_col_g), .col_b_o(w_col_b),
    .row_o(w_row), .latch_pulse_o(w_pulse), .line_cnt_o(w_line),
    .err_short_o(w_err_s), .err_long_o(w_err_l)
  );

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Shifts n bits of 'bits' MSB first on one colour/chain; optionally STB rises with the last shift edge.
  task automatic send(input logic [15:0] bits, input int unsigned n, input int unsigned colour,
                      input int unsigned ch, input bit latch_last);
    for (int i = int'(n) - 1; i >= 0; i--) begin
      shift_clk_i = 1'b0;
      led_r_i = '0; led_g_i = '0; led_b_i = '0;
      case (colour)
        0: led_r_i[ch] = bits[i];
        1: led_g_i[ch] = bits[i];
        default: led_b_i[ch] = bits[i];
      endcase
      tick(4);
      shift_clk_i = 1'b1;
      if (latch_last && i == 0) latch_i = 1'b1;
      tick(4);
    end
    shift_clk_i = 1'b0;
    latch_i = 1'b0;
    tick(6);
  endtask

  task automatic do_latch();
    latch_i = 1'b1;
    tick(4);
    latch_i = 1'b0;
    tick(6);
  endtask

  task automatic clear_errors();
    err_clr_i = 1'b1;
    tick(1);
    err_clr_i = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      shift_clk_i = 1'($urandom); latch_i = 1'($urandom); oe_n_i = 1'($urandom);
      led_r_i = 4'($urandom); led_g_i = 4'($urandom); led_b_i = 4'($urandom);
      led_sel_i = 5'($urandom); err_clr_i = 1'b0;
      tick(1);
    end
    checks++; if (col_r_o !== 32'h0) $display("FAIL reset_col_r got %h want 0", col_r_o); else passed++;
    checks++; if (col_g_o !== 32'h0) $display("FAIL reset_col_g got %h want 0", col_g_o); else passed++;
    checks++; if (col_b_o !== 32'h0) $display("FAIL reset_col_b got %h want 0", col_b_o); else passed++;
    checks++; if (row_o !== 32'h0) $display("FAIL reset_row got %h want 0", row_o); else passed++;
    checks++; if (latch_pulse_o !== 1'b0) $display("FAIL reset_pulse got %b want 0", latch_pulse_o); else passed++;
    checks++; if (line_cnt_o !== 16'h0) $display("FAIL reset_line_cnt got %h want 0", line_cnt_o); else passed++;
    checks++; if ({err_short_o, err_long_o} !== 2'b00) $display("FAIL reset_err got %b want 00", {err_short_o, err_long_o}); else passed++;
    shift_clk_i = 1'b0; latch_i = 1'b0; oe_n_i = 1'b1;
    led_r_i = '0; led_g_i = '0; led_b_i = '0; led_sel_i = '0;
    tick(1);
    rst = 1'b1;
    tick(4);
  endtask

  task automatic test_line();
    oe_n_i = 1'b0;
    tick(6);
    p0 = pulses;
    send(16'h00B2, 8, 0, 0, 1'b0);
    do_latch();
    checks++; if (col_r_o !== 32'h0000_00B2) $display("FAIL line_col_r got %h want 000000b2", col_r_o); else passed++;
    checks++; if (col_g_o !== 32'h0) $display("FAIL line_col_g got %h want 0", col_g_o); else passed++;
    checks++; if (pulses - p0 !== 1) $display("FAIL line_pulse_cycles got %0d want 1", pulses - p0); else passed++;
    checks++; if (line_cnt_o !== 16'd1) $display("FAIL line_cnt got %0d want 1", line_cnt_o); else passed++;
    checks++; if ({err_short_o, err_long_o} !== 2'b00) $display("FAIL line_err got %b want 00", {err_short_o, err_long_o}); else passed++;
  endtask

  task automatic test_oe_row();
    led_sel_i = 5'd19;
    tick(6);
    checks++; if (row_o !== 32'h0008_0000) $display("FAIL oe_row got %h want 00080000", row_o); else passed++;
    checks++; if (col_r_o !== 32'h0000_00B2) $display("FAIL oe_col_r got %h want 000000b2", col_r_o); else passed++;
    oe_n_i = 1'b1;
    tick(6);
    checks++; if (row_o !== 32'h0) $display("FAIL oe_off_row got %h want 0", row_o); else passed++;
    checks++; if (col_r_o !== 32'h0) $display("FAIL oe_off_col_r got %h want 0", col_r_o); else passed++;
    oe_n_i = 1'b0;
    tick(6);
    checks++; if (col_r_o !== 32'h0000_00B2) $display("FAIL oe_back_col_r got %h want 000000b2", col_r_o); else passed++;
    checks++; if (row_o !== 32'h0008_0000) $display("FAIL oe_back_row got %h want 00080000", row_o); else passed++;
  endtask

  task automatic test_errors();
    send(16'h0015, 5, 0, 0, 1'b0);
    do_latch();
    checks++; if (err_short_o !== 1'b1) $display("FAIL short_flag got %b want 1", err_short_o); else passed++;
    checks++; if (err_long_o !== 1'b0) $display("FAIL short_long got %b want 0", err_long_o); else passed++;
    checks++; if (col_r_o !== 32'h0000_0055) $display("FAIL short_col_r got %h want 00000055", col_r_o); else passed++;
    clear_errors();
    checks++; if ({err_short_o, err_long_o} !== 2'b00) $display("FAIL clr_err got %b want 00", {err_short_o, err_long_o}); else passed++;
    send(16'h03A5, 10, 0, 0, 1'b0);
    do_latch();
    checks++; if (err_long_o !== 1'b1) $display("FAIL long_flag got %b want 1", err_long_o); else passed++;
    checks++; if (err_short_o !== 1'b0) $display("FAIL long_short got %b want 0", err_short_o); else passed++;
    checks++; if (col_r_o !== 32'h0000_00A5) $display("FAIL long_col_r got %h want 000000a5", col_r_o); else passed++;
    checks++; if (line_cnt_o !== 16'd3) $display("FAIL long_line_cnt got %0d want 3", line_cnt_o); else passed++;
  endtask

  task automatic test_simultaneous();
    clear_errors();
    p0 = pulses;
    send(16'h003C, 8, 1, 1, 1'b1);
    checks++; if (col_g_o !== 32'h0000_3C00) $display("FAIL simul_col_g got %h want 00003c00", col_g_o); else passed++;
    checks++; if (col_r_o !== 32'h0) $display("FAIL simul_col_r got %h want 0", col_r_o); else passed++;
    checks++; if ({err_short_o, err_long_o} !== 2'b00) $display("FAIL simul_err got %b want 00", {err_short_o, err_long_o}); else passed++;
    checks++; if (pulses - p0 !== 1) $display("FAIL simul_pulse_cycles got %0d want 1", pulses - p0); else passed++;
    checks++; if (line_cnt_o !== 16'd4) $display("FAIL simul_line_cnt got %0d want 4", line_cnt_o); else passed++;
  endtask

  task automatic test_reset_midline_wrap();
    send(16'h000F, 4, 0, 0, 1'b0);
    rst = 1'b0;
    tick(2);
    checks++; if (line_cnt_o !== 16'h0) $display("FAIL mid_rst_line_cnt got %h want 0", line_cnt_o); else passed++;
    checks++; if (col_g_o !== 32'h0) $display("FAIL mid_rst_col_g got %h want 0", col_g_o); else passed++;
    rst = 1'b1;
    tick(8);
    send(16'h005A, 8, 2, 3, 1'b0);
    do_latch();
    checks++; if (col_b_o !== 32'h5A00_0000) $display("FAIL mid_line_col_b got %h want 5a000000", col_b_o); else passed++;
    checks++; if (col_r_o !== 32'h0) $display("FAIL mid_line_col_r got %h want 0", col_r_o); else passed++;
    checks++; if ({err_short_o, err_long_o} !== 2'b00) $display("FAIL mid_line_err got %b want 00", {err_short_o, err_long_o}); else passed++;
    checks++; if (line_cnt_o !== 16'd1) $display("FAIL mid_line_cnt got %0d want 1", line_cnt_o); else passed++;
    checks++; if (w_line !== 4'd1) $display("FAIL wrap_start got %0d want 1", w_line); else passed++;
    for (int i = 0; i < 14; i++) do_latch();
    checks++; if (w_line !== 4'hF) $display("FAIL wrap_max got %h want f", w_line); else passed++;
    do_latch();
    checks++; if (w_line !== 4'h0) $display("FAIL wrap_zero got %h want 0", w_line); else passed++;
    checks++; if (line_cnt_o !== 16'd16) $display("FAIL wide_line_cnt got %0d want 16", line_cnt_o); else passed++;
  endtask

  initial begin
    test_reset();
    test_line();
    test_oe_row();
    test_errors();
    test_simultaneous();
    test_reset_midline_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
